// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - four-phase RAM handshake responder over a 2**ADDR_W byte big-endian array
// Optional RAM_ALIGN_CHECK_EN adds ramERR and refuses misaligned halfword/word accesses.
module ram_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              ramMFA,
  input  logic              ramRW,
  input  logic [1:0]        ramDataSize,
  input  logic [ADDR_W-1:0] ramAddress,
  input  logic [31:0]       ramDataIn,
  output logic [31:0]       ramDataOut,
  output logic              ramMFC,
`ifdef RAM_ALIGN_CHECK_EN
  output logic              ramERR,
`endif
  output logic              ramBusy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       dout_q, dout_d;
  logic              mfc_q, mfc_d;
`ifdef RAM_ALIGN_CHECK_EN
  logic              err_q, err_d;
  logic              misalign;
`endif

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [31:0]       rd_data;
  logic              access;
  logic              wr_en;

  always_comb begin
    a0 = addr_q;
    case (size_q)
      2'b00:   a0 = addr_q;
      2'b01:   a0 = {addr_q[ADDR_W-1:1], 1'b0};
      default: a0 = {addr_q[ADDR_W-1:2], 2'b00};
    endcase
    a1 = a0 + ADDR_W'(1);
    a2 = a0 + ADDR_W'(2);
    a3 = a0 + ADDR_W'(3);
  end

  always_comb begin
    rd_data = 32'h0;
    case (size_q)
      2'b00:   rd_data = {24'h0, mem[a0]};
      2'b01:   rd_data = {16'h0, mem[a0], mem[a1]};
      default: rd_data = {mem[a0], mem[a1], mem[a2], mem[a3]};
    endcase
  end

`ifdef RAM_ALIGN_CHECK_EN
  assign misalign = ((size_q == 2'b01) && addr_q[0]) || (size_q[1] && (addr_q[1:0] != 2'b00));
`endif

  // Counter is loaded with WAIT_CYCLES+1 so the access edge is the one where it reads 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    mfc_d   = mfc_q;
    access  = 1'b0;
`ifdef RAM_ALIGN_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (ramMFA) begin
          addr_d  = ramAddress;
          rw_d    = ramRW;
          size_d  = ramDataSize;
          wdata_d = ramDataIn;
          cnt_d   = 5'(WAIT_CYCLES + 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!ramMFA) begin
          cnt_d   = 5'd0;
          state_d = IDLE;
        end else if (cnt_q == 5'd1) begin
          access  = 1'b1;
          mfc_d   = 1'b1;
          cnt_d   = 5'd0;
          state_d = DONE;
`ifdef RAM_ALIGN_CHECK_EN
          if (misalign) begin
            access = 1'b0;
            err_d  = 1'b1;
          end
`endif
          if (access && rw_q) dout_d = rd_data;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      DONE: begin
        if (!ramMFA) begin
          mfc_d   = 1'b0;
          state_d = IDLE;
`ifdef RAM_ALIGN_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    wr_en = access && !rw_q;
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      size_q  <= 2'b00;
      wdata_q <= 32'h0;
      dout_q  <= 32'h0;
      mfc_q   <= 1'b0;
`ifdef RAM_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      mfc_q   <= mfc_d;
`ifdef RAM_ALIGN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Contents survive reset, so the array has no reset branch.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      case (size_q)
        2'b00: mem[a0] <= wdata_q[7:0];
        2'b01: begin
          mem[a0] <= wdata_q[15:8];
          mem[a1] <= wdata_q[7:0];
        end
        default: begin
          mem[a0] <= wdata_q[31:24];
          mem[a1] <= wdata_q[23:16];
          mem[a2] <= wdata_q[15:8];
          mem[a3] <= wdata_q[7:0];
        end
      endcase
    end
  end

  assign ramDataOut = dout_q;
  assign ramMFC     = mfc_q;
  assign ramBusy    = (state_q != IDLE);
`ifdef RAM_ALIGN_CHECK_EN
  assign ramERR     = err_q;
`endif

endmodule
